// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the data memory: IDLE -> ISSUE -> (WAIT) -> RESP, all outputs registered.
// Tie-break is fixed priority to r0 unless DATA_ARB_ROUND_ROBIN_EN is defined, which enables round-robin.
module data_mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [3:0]  r0_sign_mask,
  output logic        r0_ack,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [3:0]  r1_sign_mask,
  output logic        r1_ack,
  output logic [31:0] r1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_n;
  logic        gnt_id, gnt_we;
  logic        win, win_we;
  logic [31:0] win_addr, win_wdata;
  logic [3:0]  win_mask;
  logic        grant, done, rd_n, wr_n;

`ifdef DATA_ARB_ROUND_ROBIN_EN
  logic pref;  // port that wins the next tie

  always_comb begin
    win = 1'b0;
    if (r0_req && r1_req) win = pref;
    else                  win = r1_req;
  end
`else
  always_comb begin
    win = 1'b0;
    win = ~r0_req;
  end
`endif

  assign win_we    = win ? r1_we        : r0_we;
  assign win_addr  = win ? r1_addr      : r0_addr;
  assign win_wdata = win ? r1_wdata     : r0_wdata;
  assign win_mask  = win ? r1_sign_mask : r0_sign_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    done    = 1'b0;
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          grant   = 1'b1;
          state_n = ISSUE;
          rd_n    = ~win_we;
          wr_n    = win_we;
        end
      end
      ISSUE: begin
        if (gnt_we) begin
          state_n = WAIT;
        end else begin
          state_n = RESP;
          done    = 1'b1;
        end
      end
      WAIT: begin
        if (!mem_clk_stall) begin
          state_n = RESP;
          done    = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Latched request fields double as the memory-side outputs, so they hold between accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_id         <= 1'b0;
      gnt_we         <= 1'b0;
      mem_addr       <= 32'h0;
      mem_write_data <= 32'h0;
      mem_sign_mask  <= 4'h0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      r0_ack         <= 1'b0;
      r1_ack         <= 1'b0;
      r0_rdata       <= 32'h0;
      r1_rdata       <= 32'h0;
      busy           <= 1'b0;
    end else begin
      mem_memread  <= rd_n;
      mem_memwrite <= wr_n;
      r0_ack       <= done & ~gnt_id;
      r1_ack       <= done & gnt_id;
      busy         <= (state_n != IDLE);
      if (grant) begin
        gnt_id         <= win;
        gnt_we         <= win_we;
        mem_addr       <= win_addr;
        mem_write_data <= win_wdata;
        mem_sign_mask  <= win_mask;
      end
      if (state == ISSUE && !gnt_we) begin
        if (gnt_id) r1_rdata <= mem_read_data;
        else        r0_rdata <= mem_read_data;
      end
    end
  end

`ifdef DATA_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      pref <= 1'b0;
    else if (grant) pref <= ~win;
  end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed-vector bench for data_mem_arbiter; tie test follows DATA_ARB_ROUND_ROBIN_EN.
module tb_data_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [31:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
  logic [3:0]  r0_sign_mask = 0, r1_sign_mask = 0;
  logic        r0_ack, r1_ack, mem_memwrite, mem_memread, busy;
  logic [31:0] r0_rdata, r1_rdata, mem_addr, mem_write_data, mem_read_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_clk_stall = 1'b0;
  int checks = 0;
  int errors = 0;

  data_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_sign_mask(r0_sign_mask), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_sign_mask(r1_sign_mask), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite),
    .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask),
    .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall), .busy(busy)
  );

  always #5 clk = ~clk;

  // Combinational memory read model
  always_comb begin
    mem_read_data = {mem_addr[15:0], 16'hC0DE};
    if (mem_addr == 32'h10) mem_read_data = 32'hDEADBEEF;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({r0_ack, r1_ack, busy, mem_memread, mem_memwrite} !== 5'b0 ||
        r0_rdata !== 0 || r1_rdata !== 0 || mem_addr !== 0 ||
        mem_write_data !== 0 || mem_sign_mask !== 0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b%b busy=%b rd=%b wr=%b addr=%h got nonzero, need all 0",
               r0_ack, r1_ack, busy, mem_memread, mem_memwrite, mem_addr);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b need 0", busy); end
  endtask

  task automatic test_load();
    r0_req = 1; r0_we = 0; r0_addr = 32'h10; r0_sign_mask = 4'h2;
    step();
    checks++;
    if (mem_memread !== 1 || mem_memwrite !== 0 || mem_addr !== 32'h10 || mem_sign_mask !== 4'h2 ||
        busy !== 1 || r0_ack !== 0) begin
      errors++;
      $display("FAIL load_issue: rd=%b wr=%b addr=%h mask=%h busy=%b ack=%b need 1 0 10 2 1 0",
               mem_memread, mem_memwrite, mem_addr, mem_sign_mask, busy, r0_ack);
    end
    step();
    checks++;
    if (r0_ack !== 1 || r0_rdata !== 32'hDEADBEEF || mem_memread !== 0 || r1_ack !== 0) begin
      errors++;
      $display("FAIL load_resp: ack=%b rdata=%h rd=%b r1_ack=%b need 1 deadbeef 0 0",
               r0_ack, r0_rdata, mem_memread, r1_ack);
    end
    r0_req = 0;
    step();
    checks++;
    if (r0_ack !== 0 || busy !== 0 || r0_rdata !== 32'hDEADBEEF || mem_addr !== 32'h10) begin
      errors++;
      $display("FAIL load_done: ack=%b busy=%b rdata=%h addr=%h need 0 0 deadbeef 10",
               r0_ack, busy, r0_rdata, mem_addr);
    end
  endtask

  task automatic test_store();
    r1_req = 1; r1_we = 1; r1_addr = 32'h2000; r1_wdata = 32'hA5; r1_sign_mask = 4'h0;
    step();
    checks++;
    if (mem_memwrite !== 1 || mem_memread !== 0 || mem_addr !== 32'h2000 || mem_write_data !== 32'hA5) begin
      errors++;
      $display("FAIL store_issue: wr=%b rd=%b addr=%h data=%h need 1 0 2000 a5",
               mem_memwrite, mem_memread, mem_addr, mem_write_data);
    end
    mem_clk_stall = 1;
    step();
    checks++;
    if (mem_memwrite !== 0 || mem_addr !== 32'h2000 || mem_write_data !== 32'hA5 || r1_ack !== 0 || busy !== 1) begin
      errors++;
      $display("FAIL store_wait: wr=%b addr=%h data=%h ack=%b busy=%b need 0 2000 a5 0 1",
               mem_memwrite, mem_addr, mem_write_data, r1_ack, busy);
    end
    mem_clk_stall = 0;
    r1_req = 0;  // withdrawal after grant must not abort
    step();
    checks++;
    if (r1_ack !== 1 || r0_ack !== 0 || r0_rdata !== 32'hDEADBEEF || r1_rdata !== 0 ||
        mem_addr !== 32'h2000) begin
      errors++;
      $display("FAIL store_resp: r1_ack=%b r0_ack=%b r0_rdata=%h r1_rdata=%h addr=%h need 1 0 deadbeef 0 2000",
               r1_ack, r0_ack, r0_rdata, r1_rdata, mem_addr);
    end
    step();
    checks++;
    if (r1_ack !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL store_done: ack=%b busy=%b need 0 0", r1_ack, busy);
    end
  endtask

  task automatic test_tie();
    logic e0, e1;
    reset = 1; #2; reset = 0;
    r0_req = 1; r0_we = 0; r0_addr = 32'h10;
    r1_req = 1; r1_we = 0; r1_addr = 32'h44;
    for (int k = 0; k < 8; k++) begin
      step();
`ifdef DATA_ARB_ROUND_ROBIN_EN
      e0 = (k == 1 || k == 7);
      e1 = (k == 4);
`else
      e0 = (k == 1 || k == 4 || k == 7);
      e1 = 1'b0;
`endif
      checks++;
      if (r0_ack !== e0 || r1_ack !== e1) begin
        errors++;
        $display("FAIL tie_ack cycle %0d: r0_ack=%b r1_ack=%b need %b %b", k + 2, r0_ack, r1_ack, e0, e1);
      end
    end
    checks++;
`ifdef DATA_ARB_ROUND_ROBIN_EN
    if (r1_rdata !== 32'h0044C0DE || r0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL tie_rdata: r0=%h r1=%h need deadbeef 0044c0de", r0_rdata, r1_rdata);
    end
`else
    if (r1_rdata !== 32'h0 || r0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL tie_rdata: r0=%h r1=%h need deadbeef 0", r0_rdata, r1_rdata);
    end
`endif
    r0_req = 0; r1_req = 0;
    step(); step();
    checks++;
    if (busy !== 0) begin errors++; $display("FAIL tie_idle: busy=%b need 0", busy); end
  endtask

  task automatic test_reset_in_wait();
    r1_req = 1; r1_we = 1; r1_addr = 32'h2000; r1_wdata = 32'h5A;
    mem_clk_stall = 1;
    step(); step(); step();
    checks++;
    if (busy !== 1 || mem_memwrite !== 0 || r1_ack !== 0 || mem_addr !== 32'h2000) begin
      errors++;
      $display("FAIL wait_stall: busy=%b wr=%b ack=%b addr=%h need 1 0 0 2000", busy, mem_memwrite, r1_ack, mem_addr);
    end
    reset = 1;
    #1;
    checks++;
    if ({r0_ack, r1_ack, busy, mem_memread, mem_memwrite} !== 5'b0 || mem_addr !== 0 ||
        mem_write_data !== 0 || r0_rdata !== 0) begin
      errors++;
      $display("FAIL reset_in_wait: ack=%b%b busy=%b addr=%h data=%h need all 0",
               r0_ack, r1_ack, busy, mem_addr, mem_write_data);
    end
    r1_req = 0; mem_clk_stall = 0;
    step();
    reset = 0;
    step();
    checks++;
    if (busy !== 0 || r1_ack !== 0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b ack=%b need 0 0", busy, r1_ack);
    end
    r0_req = 1; r0_we = 0; r0_addr = 32'h10;
    step(); step();
    checks++;
    if (r0_ack !== 1 || r0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL post_reset_load: ack=%b rdata=%h need 1 deadbeef", r0_ack, r0_rdata);
    end
    r0_req = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_tie();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL be clocked by clk and reset by reset; one clock; reset is asynchronous and active-high.
REQ-002 Ports (name  direction  width  meaning):
  clk  input  1  system clock, rising edge
  reset  input  1  asynchronous active-high reset
  r0_req / r1_req  input  1  requester 0 (CPU data port) / requester 1 (debug/DMA port) access request
  r0_we / r1_we  input  1  1 = store, 0 = load
  r0_addr / r1_addr  input  32  byte address
  r0_wdata / r1_wdata  input  32  store data
  r0_sign_mask / r1_sign_mask  input  4  size/sign code, same encoding as data memory
  r0_ack / r1_ack  output  1  one-cycle completion pulse
  r0_rdata / r1_rdata  output  32  load data, valid while the port's ack is high
  mem_addr  output  32  data memory address
  mem_write_data  output  32  data memory store data
  mem_memwrite  output  1  data memory write strobe
  mem_memread  output  1  data memory read strobe
  mem_sign_mask  output  4  data memory size/sign code
  mem_read_data  input  32  data memory read result
  mem_clk_stall  input  1  data memory busy (write in progress)
  busy  output  1  high in any state other than IDLE

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-004 IDLE: if any rN_req is sampled high, the winner is latched (id, we, addr, wdata, sign_mask) and the FSM goes to ISSUE; otherwise it stays in IDLE.
REQ-005 ISSUE: mem_addr/mem_write_data/mem_sign_mask SHALL carry the latched fields; mem_memread = ~we; mem_memwrite = we; next state is WAIT if we, else RESP.
REQ-006 WAIT: mem_memwrite = 0; address/data/sign_mask held; stay while mem_clk_stall = 1, go to RESP when mem_clk_stall = 0 is sampled.
REQ-007 RESP: the winner's ack = 1 for exactly one cycle; for a load, rdata = mem_read_data captured at the end of ISSUE; then IDLE.
REQ-008 Load latency SHALL be 2 cycles (req sampled -> ack high); store latency SHALL be 3 cycles with no extra stall.
REQ-009 A requester SHALL hold req and its fields stable until it samples ack; a withdrawn req SHALL NOT abort an access already granted.
REQ-010 Sampled in RESP, a still-high req SHALL be treated as a new request in the following IDLE cycle; no back-to-back grant out of RESP.
REQ-011 Simultaneous r0_req and r1_req SHALL be resolved per REQ-017/018; the loser waits in its held state, with no ack and no data loss.
REQ-012 The non-granted port's ack SHALL be 0 and its rdata SHALL hold its last value.
REQ-013 Outside ISSUE/WAIT: mem_memread = mem_memwrite = 0; mem_addr/mem_write_data/mem_sign_mask hold last value (0 after reset).
REQ-014 Address 0x2000 (LED) SHALL be passed through like any other address; no decoding in this block.

Reset
REQ-015 On reset: state IDLE, all acks 0, rdata 0, all mem_* outputs 0, busy 0, round-robin pointer = port 0 preferred.
REQ-016 Reset during WAIT SHALL abandon the access with no ack; data memory completion of that write is not guaranteed.

Configuration
REQ-017 With DATA_ARB_ROUND_ROBIN_EN defined: on a tie, the port not granted last wins; the pointer updates only on a grant.
REQ-018 Without DATA_ARB_ROUND_ROBIN_EN: fixed priority, r0 always wins ties; no pointer register exists.

Verification
REQ-019 r0 load addr 0x10 (mem returns 0xDEADBEEF), r1 idle -> r0_ack high 2 cycles after req, r0_rdata = 0xDEADBEEF, mem_memread high for 1 cycle.
REQ-020 r1 store addr 0x2000 data 0xA5, mem_clk_stall high 1 cycle -> mem_memwrite high 1 cycle, r1_ack 3 cycles after req, addr/data held through WAIT.
REQ-021 r0 and r1 load requests raised in the same cycle, RR enabled -> r0 acked first, r1 acked 3 cycles later; repeat tie -> r1 first.
REQ-022 Same tie with macro undefined, r0_req held continuously -> r0 acked every 3 cycles; r1 stays pending with r1_ack = 0.
REQ-023 Reset asserted in WAIT of a store -> all outputs 0 immediately, no ack, IDLE after release; next r0 load completes in 2 cycles.
